// File: rtl/pipeline_control_unit_if.sv
// Signal bundle between the pipeline control unit and the datapath stage registers.
// The datapath side (master) supplies decode fields and EX status; the control unit (slave) returns control bits.
interface pipeline_control_unit_if #(
  parameter int ADDR_W = 5
);
  logic [6:0]        id_opcode;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_redirect;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              ex_alusrc;
  logic              ex_branch;
  logic              ex_jump;
  logic              ex_jumpreg;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_memtoreg;
  logic              ex_regwrite;
  logic [1:0]        ex_aluop;
  logic              mem_memread;
  logic              mem_memwrite;
  logic              mem_memtoreg;
  logic              mem_regwrite;
  logic              wb_memtoreg;
  logic              wb_regwrite;
  logic              halted;

  modport master (
    output id_opcode, id_rs1, id_rs2, ex_rd, ex_redirect,
    input  pc_write, if_id_write, if_id_flush,
    input  ex_alusrc, ex_branch, ex_jump, ex_jumpreg, ex_memread, ex_memwrite,
    input  ex_memtoreg, ex_regwrite, ex_aluop,
    input  mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite,
    input  wb_memtoreg, wb_regwrite, halted
  );

  modport slave (
    input  id_opcode, id_rs1, id_rs2, ex_rd, ex_redirect,
    output pc_write, if_id_write, if_id_flush,
    output ex_alusrc, ex_branch, ex_jump, ex_jumpreg, ex_memread, ex_memwrite,
    output ex_memtoreg, ex_regwrite, ex_aluop,
    output mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite,
    output wb_memtoreg, wb_regwrite, halted
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// RISC-V pipelined main control: opcode decode, ID/EX->EX/MEM->MEM/WB control registers,
// load-use stall, redirect flush and a halt-drain FSM that freezes the core once older work retires.
module pipeline_control_unit #(
  parameter int ADDR_W       = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input logic                    clk,
  input logic                    reset,
  pipeline_control_unit_if.slave bus
);
  typedef struct packed {
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       jumpreg;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_HALT  = 7'b1111111;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  function automatic ctrl_t decode(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R:     begin c.regwrite = 1'b1; c.aluop = 2'b10; end
      OP_LOAD:  begin c.alusrc = 1'b1; c.memread = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      OP_STORE: begin c.alusrc = 1'b1; c.memwrite = 1'b1; end
      OP_BR:    begin c.branch = 1'b1; c.aluop = 2'b01; end
      OP_I:     begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = 2'b10; end
      OP_LUI:   begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = 2'b11; end
      OP_JAL:   begin c.jump = 1'b1; c.regwrite = 1'b1; c.aluop = 2'b01; end
      OP_JALR:  begin c.alusrc = 1'b1; c.jump = 1'b1; c.jumpreg = 1'b1; c.regwrite = 1'b1;
                      c.aluop = 2'b11; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BR) ||
           (op == OP_I) || (op == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BR);
  endfunction

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       halted_q, halted_d;
  ctrl_t      ex_q, ex_d;
  logic [3:0] mem_q, mem_d;   // {memread, memwrite, memtoreg, regwrite}
  logic [1:0] wb_q, wb_d;     // {memtoreg, regwrite}
  ctrl_t      dec;
  logic       load_use;
  logic       pc_write_d, if_id_write_d, if_id_flush_d;

  always_comb begin
    dec      = decode(bus.id_opcode);
    load_use = ex_q.memread && (bus.ex_rd != REG_ZERO) &&
               ((uses_rs1(bus.id_opcode) && (bus.ex_rd == bus.id_rs1)) ||
                (uses_rs2(bus.id_opcode) && (bus.ex_rd == bus.id_rs2)));
    state_d       = state_q;
    cnt_d         = cnt_q;
    ex_d          = '0;
    pc_write_d    = 1'b0;
    if_id_write_d = 1'b0;
    if_id_flush_d = 1'b0;
    mem_d         = {ex_q.memread, ex_q.memwrite, ex_q.memtoreg, ex_q.regwrite};
    wb_d          = {mem_q[1], mem_q[0]};
    case (state_q)
      RUN: begin
        // A redirect makes any HALT in ID wrong-path, so it wins over the halt request.
        if (bus.ex_redirect) begin
          pc_write_d    = 1'b1;
          if_id_write_d = 1'b1;
          if_id_flush_d = 1'b1;
        end else if (bus.id_opcode == OP_HALT) begin
          state_d = DRAIN;
          cnt_d   = 4'(DRAIN_CYCLES);
        end else if (!load_use) begin
          pc_write_d    = 1'b1;
          if_id_write_d = 1'b1;
          ex_d          = dec;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = HALTED;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);
    if (reset) begin
      pc_write_d    = 1'b0;
      if_id_write_d = 1'b0;
      if_id_flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= 4'd0;
      halted_q <= 1'b0;
      ex_q     <= '0;
      mem_q    <= 4'd0;
      wb_q     <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
    end
  end

  assign bus.pc_write     = pc_write_d;
  assign bus.if_id_write  = if_id_write_d;
  assign bus.if_id_flush  = if_id_flush_d;
  assign bus.ex_alusrc    = ex_q.alusrc;
  assign bus.ex_branch    = ex_q.branch;
  assign bus.ex_jump      = ex_q.jump;
  assign bus.ex_jumpreg   = ex_q.jumpreg;
  assign bus.ex_memread   = ex_q.memread;
  assign bus.ex_memwrite  = ex_q.memwrite;
  assign bus.ex_memtoreg  = ex_q.memtoreg;
  assign bus.ex_regwrite  = ex_q.regwrite;
  assign bus.ex_aluop     = ex_q.aluop;
  assign bus.mem_memread  = mem_q[3];
  assign bus.mem_memwrite = mem_q[2];
  assign bus.mem_memtoreg = mem_q[1];
  assign bus.mem_regwrite = mem_q[0];
  assign bus.wb_memtoreg  = wb_q[1];
  assign bus.wb_regwrite  = wb_q[0];
  assign bus.halted       = halted_q;
endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench: a default build (DRAIN_CYCLES=3) and a DRAIN_CYCLES=1 build side by side.
module tb_pipeline_control_unit;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_HALT = 7'b1111111;
  localparam logic [6:0] OP_NOP = 7'b0000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  pipeline_control_unit_if #(.ADDR_W(5)) ifc0 ();
  pipeline_control_unit_if #(.ADDR_W(5)) ifc1 ();

  pipeline_control_unit #(.ADDR_W(5), .DRAIN_CYCLES(3)) dut0 (.clk(clk), .reset(reset), .bus(ifc0));
  pipeline_control_unit #(.ADDR_W(5), .DRAIN_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(ifc1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Bundle order: alusrc branch jump jumpreg memread memwrite memtoreg regwrite aluop[1:0]
  function automatic logic [9:0] bun0();
    return {ifc0.ex_alusrc, ifc0.ex_branch, ifc0.ex_jump, ifc0.ex_jumpreg, ifc0.ex_memread,
            ifc0.ex_memwrite, ifc0.ex_memtoreg, ifc0.ex_regwrite, ifc0.ex_aluop};
  endfunction

  function automatic logic [9:0] bun1();
    return {ifc1.ex_alusrc, ifc1.ex_branch, ifc1.ex_jump, ifc1.ex_jumpreg, ifc1.ex_memread,
            ifc1.ex_memwrite, ifc1.ex_memtoreg, ifc1.ex_regwrite, ifc1.ex_aluop};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic rdr);
    ifc0.id_opcode = op; ifc0.id_rs1 = r1; ifc0.id_rs2 = r2;
    ifc0.ex_rd = rd; ifc0.ex_redirect = rdr;
  endtask

  task automatic set1(input logic [6:0] op);
    ifc1.id_opcode = op; ifc1.id_rs1 = 5'd0; ifc1.id_rs2 = 5'd0;
    ifc1.ex_rd = 5'd0; ifc1.ex_redirect = 1'b0;
  endtask

  task automatic test_reset();
    set0(OP_NOP, 0, 0, 0, 0);
    set1(OP_NOP);
    reset = 1'b1;
    tick();
    n_cmp++; if ({ifc0.pc_write, ifc0.if_id_write, ifc0.if_id_flush} !== 3'b001) begin
      n_bad++; $display("FAIL reset_hazard_outs: got %b want 001",
                        {ifc0.pc_write, ifc0.if_id_write, ifc0.if_id_flush}); end
    n_cmp++; if ({bun0(), ifc0.mem_regwrite, ifc0.wb_regwrite, ifc0.halted} !== 13'd0) begin
      n_bad++; $display("FAIL reset_state: got %h want 0",
                        {bun0(), ifc0.mem_regwrite, ifc0.wb_regwrite, ifc0.halted}); end
    reset = 1'b0;
    #1;
    n_cmp++; if (ifc0.pc_write !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_pc_write: got %b want 1", ifc0.pc_write); end
  endtask

  task automatic test_addi();
    set0(OP_I, 5'd1, 5'd0, 5'd0, 1'b0);
    #1;
    n_cmp++; if (ifc0.pc_write !== 1'b1) begin
      n_bad++; $display("FAIL addi_pc_write: got %b want 1", ifc0.pc_write); end
    tick();
    n_cmp++; if (bun0() !== 10'b1000000110) begin
      n_bad++; $display("FAIL addi_ex_bundle: got %b want 1000000110", bun0()); end
    set0(OP_NOP, 0, 0, 0, 0);
    tick();
    n_cmp++; if (ifc0.mem_regwrite !== 1'b1) begin
      n_bad++; $display("FAIL addi_mem_regwrite: got %b want 1", ifc0.mem_regwrite); end
    tick();
    n_cmp++; if ({ifc0.wb_regwrite, ifc0.wb_memtoreg, ifc0.pc_write} !== 3'b101) begin
      n_bad++; $display("FAIL addi_wb: got %b want 101",
                        {ifc0.wb_regwrite, ifc0.wb_memtoreg, ifc0.pc_write}); end
  endtask

  task automatic test_load_use();
    set0(OP_LOAD, 5'd2, 5'd0, 5'd0, 1'b0);
    tick();
    set0(OP_R, 5'd1, 5'd5, 5'd5, 1'b0);
    #1;
    n_cmp++; if ({ifc0.pc_write, ifc0.if_id_write, ifc0.if_id_flush} !== 3'b000) begin
      n_bad++; $display("FAIL lu_stall: got %b want 000",
                        {ifc0.pc_write, ifc0.if_id_write, ifc0.if_id_flush}); end
    tick();
    n_cmp++; if ({bun0(), ifc0.mem_memread, ifc0.mem_memtoreg} !== 12'b000000000011) begin
      n_bad++; $display("FAIL lu_bubble: got %b want 000000000011",
                        {bun0(), ifc0.mem_memread, ifc0.mem_memtoreg}); end
    set0(OP_R, 5'd1, 5'd5, 5'd0, 1'b0);
    #1;
    n_cmp++; if (ifc0.pc_write !== 1'b1) begin
      n_bad++; $display("FAIL lu_one_cycle: got %b want 1", ifc0.pc_write); end
    tick();
    n_cmp++; if (bun0() !== 10'b0000000110) begin
      n_bad++; $display("FAIL lu_add_bundle: got %b want 0000000110", bun0()); end
    set0(OP_LOAD, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    set0(OP_R, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    n_cmp++; if (ifc0.pc_write !== 1'b1) begin
      n_bad++; $display("FAIL lu_rd_zero: got %b want 1", ifc0.pc_write); end
    tick();
    set0(OP_LOAD, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    set0(OP_LUI, 5'd5, 5'd0, 5'd5, 1'b0);
    #1;
    n_cmp++; if (ifc0.if_id_write !== 1'b1) begin
      n_bad++; $display("FAIL lu_lui_no_stall: got %b want 1", ifc0.if_id_write); end
    tick();
    n_cmp++; if (bun0() !== 10'b1000000111) begin
      n_bad++; $display("FAIL lui_bundle: got %b want 1000000111", bun0()); end
    set0(OP_LOAD, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    set0(OP_I, 5'd5, 5'd0, 5'd5, 1'b0);
    #1;
    n_cmp++; if (ifc0.pc_write !== 1'b0) begin
      n_bad++; $display("FAIL lu_rs1_stall: got %b want 0", ifc0.pc_write); end
    tick();
    set0(OP_NOP, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_redirect_halt();
    set0(OP_HALT, 5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    n_cmp++; if ({ifc0.pc_write, ifc0.if_id_write, ifc0.if_id_flush} !== 3'b111) begin
      n_bad++; $display("FAIL redir_outs: got %b want 111",
                        {ifc0.pc_write, ifc0.if_id_write, ifc0.if_id_flush}); end
    tick();
    set0(OP_NOP, 0, 0, 0, 0);
    #1;
    n_cmp++; if ({bun0(), ifc0.pc_write} !== 11'b00000000001) begin
      n_bad++; $display("FAIL redir_stay_run: got %b want 00000000001", {bun0(), ifc0.pc_write}); end
    repeat (4) tick();
    n_cmp++; if (ifc0.halted !== 1'b0) begin
      n_bad++; $display("FAIL redir_no_halt: got %b want 0", ifc0.halted); end
  endtask

  task automatic test_halt_drain();
    set0(OP_STORE, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    set0(OP_HALT, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    n_cmp++; if ({ifc0.pc_write, ifc0.if_id_write, ifc0.ex_memwrite} !== 3'b001) begin
      n_bad++; $display("FAIL halt_n: got %b want 001",
                        {ifc0.pc_write, ifc0.if_id_write, ifc0.ex_memwrite}); end
    tick();
    set0(OP_HALT, 5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    n_cmp++; if ({ifc0.mem_memwrite, ifc0.if_id_flush, ifc0.pc_write, ifc0.halted} !== 4'b1000) begin
      n_bad++; $display("FAIL halt_n1: got %b want 1000",
                        {ifc0.mem_memwrite, ifc0.if_id_flush, ifc0.pc_write, ifc0.halted}); end
    set0(OP_HALT, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    n_cmp++; if (ifc0.halted !== 1'b0) begin
      n_bad++; $display("FAIL halt_n3_early: got %b want 0", ifc0.halted); end
    tick();
    n_cmp++; if ({ifc0.halted, ifc0.pc_write} !== 2'b10) begin
      n_bad++; $display("FAIL halt_n4: got %b want 10", {ifc0.halted, ifc0.pc_write}); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({ifc0.halted, ifc0.pc_write, ifc0.if_id_flush} !== 3'b001) begin
      n_bad++; $display("FAIL halted_reset: got %b want 001",
                        {ifc0.halted, ifc0.pc_write, ifc0.if_id_flush}); end
    reset = 1'b0;
    set0(OP_NOP, 0, 0, 0, 0);
    #1;
    n_cmp++; if (ifc0.pc_write !== 1'b1) begin
      n_bad++; $display("FAIL halted_reset_run: got %b want 1", ifc0.pc_write); end
    tick();
    set0(OP_I, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    set0(OP_HALT, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    n_cmp++; if (ifc0.wb_regwrite !== 1'b1) begin
      n_bad++; $display("FAIL drain_wb_n2: got %b want 1", ifc0.wb_regwrite); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({ifc0.halted, ifc0.pc_write} !== 2'b00) begin
      n_bad++; $display("FAIL drain_reset: got %b want 00", {ifc0.halted, ifc0.pc_write}); end
    tick();
    reset = 1'b0;
    set0(OP_I, 5'd1, 5'd0, 5'd0, 1'b0);
    #1;
    n_cmp++; if (ifc0.pc_write !== 1'b1) begin
      n_bad++; $display("FAIL drain_reset_run: got %b want 1", ifc0.pc_write); end
    tick();
    n_cmp++; if (bun0() !== 10'b1000000110) begin
      n_bad++; $display("FAIL drain_reset_decode: got %b want 1000000110", bun0()); end
    set0(OP_NOP, 0, 0, 0, 0);
    repeat (4) tick();
    n_cmp++; if (ifc0.halted !== 1'b0) begin
      n_bad++; $display("FAIL drain_reset_cleared: got %b want 0", ifc0.halted); end
  endtask

  task automatic test_decode_all();
    logic [6:0] ops [9];
    logic [9:0] exp [9];
    ops = '{OP_R, OP_LOAD, OP_STORE, OP_BR, OP_I, OP_LUI, OP_JAL, OP_JALR, 7'b0001011};
    exp = '{10'b0000000110, 10'b1000101100, 10'b1000010000, 10'b0100000001, 10'b1000000110,
            10'b1000000111, 10'b0010000101, 10'b1011000111, 10'b0000000000};
    for (int i = 0; i < 9; i++) begin
      set1(ops[i]);
      tick();
      n_cmp++; if (bun1() !== exp[i]) begin
        n_bad++; $display("FAIL decode_%0d op=%b: got %b want %b", i, ops[i], bun1(), exp[i]); end
    end
  endtask

  task automatic test_drain1();
    set1(OP_NOP);
    tick();
    set1(OP_HALT);
    #1;
    n_cmp++; if (ifc1.pc_write !== 1'b0) begin
      n_bad++; $display("FAIL d1_halt_pc_write: got %b want 0", ifc1.pc_write); end
    tick();
    n_cmp++; if (ifc1.halted !== 1'b0) begin
      n_bad++; $display("FAIL d1_n1: got %b want 0", ifc1.halted); end
    set1(OP_NOP);
    tick();
    n_cmp++; if ({ifc1.halted, ifc1.pc_write} !== 2'b10) begin
      n_bad++; $display("FAIL d1_n2: got %b want 10", {ifc1.halted, ifc1.pc_write}); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_redirect_halt();
    test_decode_all();
    test_drain1();
    test_halt_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
